// File: rtl/t01_wb_arb_manager.sv
// t01_wb_arb_manager: per-channel request slots, round-robin arbitrated onto one classic Wishbone bus.
// Latency: request edge -> CYC_O high two cycles later; ACK edge -> done pulse and CYC_O low next cycle.
// Backpressure: one slot per channel; requests on a busy slot are dropped. Optional ACK timeout: T01_WB_TIMEOUT_EN.
module t01_wb_arb_manager #(
    parameter int NUM_CH  = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_CH-1:0]            req_read_i,
    input  logic [NUM_CH-1:0]            req_write_i,
    input  logic [NUM_CH*ADDR_W-1:0]     req_adr_i,
    input  logic [NUM_CH*DATA_W-1:0]     req_dat_i,
    input  logic [NUM_CH*(DATA_W/8)-1:0] req_sel_i,
    output logic [DATA_W-1:0]            req_dat_o,
    output logic [NUM_CH-1:0]            req_busy_o,
    output logic [NUM_CH-1:0]            req_done_o,
    output logic [NUM_CH-1:0]            req_err_o,
    input  logic [DATA_W-1:0]            DAT_I,
    input  logic                         ACK_I,
    output logic [ADDR_W-1:0]            ADR_O,
    output logic [DATA_W-1:0]            DAT_O,
    output logic [DATA_W/8-1:0]          SEL_O,
    output logic                         WE_O,
    output logic                         STB_O,
    output logic                         CYC_O
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Elaboration-time guard on the supported parameter range
    if (NUM_CH < 2 || NUM_CH > 8 || (DATA_W % 8) != 0 || TIMEOUT < 1) begin : g_bad_param
        $error("t01_wb_arb_manager: unsupported parameter set");
    end

    // Per-channel request slots
    logic [NUM_CH-1:0] slot_full_q, slot_full_d;
    logic [NUM_CH-1:0] slot_we_q, slot_we_d;
    logic [ADDR_W-1:0] slot_adr_q [NUM_CH];
    logic [ADDR_W-1:0] slot_adr_d [NUM_CH];
    logic [DATA_W-1:0] slot_dat_q [NUM_CH];
    logic [DATA_W-1:0] slot_dat_d [NUM_CH];
    logic [SEL_W-1:0]  slot_sel_q [NUM_CH];
    logic [SEL_W-1:0]  slot_sel_d [NUM_CH];

    // FSM, arbitration and registered bus outputs
    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0] adr_o_q, adr_o_d;
    logic [DATA_W-1:0] dat_o_q, dat_o_d;
    logic [SEL_W-1:0]  sel_o_q, sel_o_d;
    logic              we_o_q, we_o_d;
    logic              cyc_o_q, cyc_o_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic [NUM_CH-1:0] done_q, done_d;

    logic              gnt_found;
    logic [CH_W-1:0]   gnt_idx;
    logic [CH_W-1:0]   grant_next;
    logic              tmo_hit;

`ifdef T01_WB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [NUM_CH-1:0] err_q, err_d;

    // ACK on the timeout edge takes priority, so the hit is qualified by !ACK_I
    assign tmo_hit = (state_q == S_WAIT) && !ACK_I && (tmo_cnt_q == TMO_W'(TIMEOUT));

    // Wait counter: held at zero while idle so it starts from zero on entering WAIT
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == S_IDLE) begin
            tmo_cnt_d = '0;
        end else if (!ACK_I && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    // Timeout counter and abort pulse registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= err_d;
        end
    end

    assign req_err_o = err_q;
`else
    assign tmo_hit   = 1'b0;
    assign req_err_o = '0;
`endif

    // Round-robin search: first full slot starting at the pointer (last grant + 1)
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_found && slot_full_q[(int'(rr_ptr_q) + k) % NUM_CH]) begin
                gnt_found = 1'b1;
                gnt_idx   = CH_W'((int'(rr_ptr_q) + k) % NUM_CH);
            end
        end
    end

    assign grant_next = (grant_q == CH_W'(NUM_CH - 1)) ? '0 : grant_q + CH_W'(1);

    // Next-state: FSM and bus drive, then slot clear on completion and capture of new requests
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        adr_o_d     = adr_o_q;
        dat_o_d     = dat_o_q;
        sel_o_d     = sel_o_q;
        we_o_d      = we_o_q;
        cyc_o_d     = cyc_o_q;
        rdat_d      = rdat_q;
        done_d      = '0;
        slot_full_d = slot_full_q;
        slot_we_d   = slot_we_q;
        slot_adr_d  = slot_adr_q;
        slot_dat_d  = slot_dat_q;
        slot_sel_d  = slot_sel_q;
`ifdef T01_WB_TIMEOUT_EN
        err_d       = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (en && gnt_found) begin
                    adr_o_d = slot_adr_q[gnt_idx];
                    dat_o_d = slot_dat_q[gnt_idx];
                    sel_o_d = slot_sel_q[gnt_idx];
                    we_o_d  = slot_we_q[gnt_idx];
                    cyc_o_d = 1'b1;
                    grant_d = gnt_idx;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // en is deliberately ignored here: an issued cycle always runs to completion
                if (ACK_I) begin
                    if (!we_o_q) begin
                        rdat_d = DAT_I;
                    end
                    cyc_o_d              = 1'b0;
                    we_o_d               = 1'b0;
                    done_d[grant_q]      = 1'b1;
                    slot_full_d[grant_q] = 1'b0;
                    rr_ptr_d             = grant_next;
                    state_d              = S_IDLE;
                end else if (tmo_hit) begin
                    cyc_o_d              = 1'b0;
                    we_o_d               = 1'b0;
                    slot_full_d[grant_q] = 1'b0;
                    rr_ptr_d             = grant_next;
                    state_d              = S_IDLE;
`ifdef T01_WB_TIMEOUT_EN
                    err_d[grant_q]       = 1'b1;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
                cyc_o_d = 1'b0;
            end
        endcase

        // Capture is judged on the pre-edge slot state; write wins when both strobes are high
        for (int i = 0; i < NUM_CH; i++) begin
            if (en && (req_read_i[i] || req_write_i[i]) && !slot_full_q[i]) begin
                slot_full_d[i] = 1'b1;
                slot_we_d[i]   = req_write_i[i];
                slot_adr_d[i]  = req_adr_i[i*ADDR_W +: ADDR_W];
                slot_dat_d[i]  = req_dat_i[i*DATA_W +: DATA_W];
                slot_sel_d[i]  = req_sel_i[i*SEL_W +: SEL_W];
            end
        end
    end

    // State, slot and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            adr_o_q     <= '0;
            dat_o_q     <= '0;
            sel_o_q     <= '0;
            we_o_q      <= 1'b0;
            cyc_o_q     <= 1'b0;
            rdat_q      <= '0;
            done_q      <= '0;
            slot_full_q <= '0;
            slot_we_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_adr_q[i] <= '0;
                slot_dat_q[i] <= '0;
                slot_sel_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            adr_o_q     <= adr_o_d;
            dat_o_q     <= dat_o_d;
            sel_o_q     <= sel_o_d;
            we_o_q      <= we_o_d;
            cyc_o_q     <= cyc_o_d;
            rdat_q      <= rdat_d;
            done_q      <= done_d;
            slot_full_q <= slot_full_d;
            slot_we_q   <= slot_we_d;
            slot_adr_q  <= slot_adr_d;
            slot_dat_q  <= slot_dat_d;
            slot_sel_q  <= slot_sel_d;
        end
    end

    assign ADR_O      = adr_o_q;
    assign DAT_O      = dat_o_q;
    assign SEL_O      = sel_o_q;
    assign WE_O       = we_o_q;
    assign CYC_O      = cyc_o_q;
    assign STB_O      = cyc_o_q;
    assign req_dat_o  = rdat_q;
    assign req_busy_o = slot_full_q;
    assign req_done_o = done_q;

endmodule

// File: tb/tb_t01_wb_arb_manager.sv
// tb_t01_wb_arb_manager: directed bench for the two-channel arbitrated Wishbone manager.
// Inputs driven and outputs sampled on the falling edge; one linear stimulus sequence.
// Slave side is scripted directly through ACK_I/DAT_I.
module tb_t01_wb_arb_manager;
    localparam int NUM_CH = 2;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic [NUM_CH-1:0]         req_read_i;
    logic [NUM_CH-1:0]         req_write_i;
    logic [NUM_CH*ADDR_W-1:0]  req_adr_i;
    logic [NUM_CH*DATA_W-1:0]  req_dat_i;
    logic [NUM_CH*SEL_W-1:0]   req_sel_i;
    logic [DATA_W-1:0]         req_dat_o;
    logic [NUM_CH-1:0]         req_busy_o;
    logic [NUM_CH-1:0]         req_done_o;
    logic [NUM_CH-1:0]         req_err_o;
    logic [DATA_W-1:0]         DAT_I;
    logic                      ACK_I;
    logic [ADDR_W-1:0]         ADR_O;
    logic [DATA_W-1:0]         DAT_O;
    logic [SEL_W-1:0]          SEL_O;
    logic                      WE_O;
    logic                      STB_O;
    logic                      CYC_O;

    int checks = 0;
    int errors = 0;

    t01_wb_arb_manager #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .req_read_i (req_read_i),
        .req_write_i(req_write_i),
        .req_adr_i  (req_adr_i),
        .req_dat_i  (req_dat_i),
        .req_sel_i  (req_sel_i),
        .req_dat_o  (req_dat_o),
        .req_busy_o (req_busy_o),
        .req_done_o (req_done_o),
        .req_err_o  (req_err_o),
        .DAT_I      (DAT_I),
        .ACK_I      (ACK_I),
        .ADR_O      (ADR_O),
        .DAT_O      (DAT_O),
        .SEL_O      (SEL_O),
        .WE_O       (WE_O),
        .STB_O      (STB_O),
        .CYC_O      (CYC_O)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int ch, input logic rd, input logic wr,
                           input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        req_read_i[ch]               = rd;
        req_write_i[ch]              = wr;
        req_adr_i[ch*ADDR_W +: ADDR_W] = adr;
        req_dat_i[ch*DATA_W +: DATA_W] = dat;
        req_sel_i[ch*SEL_W +: SEL_W]   = sel;
    endtask

    task automatic clr_req();
        req_read_i  = '0;
        req_write_i = '0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; ACK_I = 1'b0; DAT_I = '0;
        req_read_i = '0; req_write_i = '0; req_adr_i = '0; req_dat_i = '0; req_sel_i = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_cyc",  64'(CYC_O), 64'd0);
        chk("rst_stb",  64'(STB_O), 64'd0);
        chk("rst_we",   64'(WE_O), 64'd0);
        chk("rst_adr",  64'(ADR_O), 64'd0);
        chk("rst_busy", 64'(req_busy_o), 64'd0);
        chk("rst_done", 64'(req_done_o), 64'd0);
        chk("rst_err",  64'(req_err_o), 64'd0);
        chk("rst_rdat", 64'(req_dat_o), 64'd0);
        rst = 1'b0;
        tick();

        // Single read on ch0, ACK in cycle 2
        set_req(0, 1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
        tick();
        clr_req();
        chk("rd_c1_busy", 64'(req_busy_o), 64'b01);
        chk("rd_c1_cyc",  64'(CYC_O), 64'd0);
        tick();
        chk("rd_c2_cyc", 64'(CYC_O), 64'd1);
        chk("rd_c2_stb", 64'(STB_O), 64'd1);
        chk("rd_c2_we",  64'(WE_O), 64'd0);
        chk("rd_c2_adr", 64'(ADR_O), 64'h3000_0010);
        ACK_I = 1'b1; DAT_I = 32'hDEAD_BEEF;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        chk("rd_c3_cyc",  64'(CYC_O), 64'd0);
        chk("rd_c3_done", 64'(req_done_o), 64'b01);
        chk("rd_c3_rdat", 64'(req_dat_o), 64'hDEAD_BEEF);
        chk("rd_c3_busy", 64'(req_busy_o), 64'd0);
        tick();
        chk("rd_c4_done", 64'(req_done_o), 64'd0);
        chk("rd_c4_adr_hold", 64'(ADR_O), 64'h3000_0010);

        // Reset again, then simultaneous writes on ch0 and ch1: ch0 first
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 1'b1, 32'hA000_0000, 32'h1111_0000, 4'hF);
        set_req(1, 1'b0, 1'b1, 32'hA000_0100, 32'h2222_0001, 4'hC);
        tick();
        clr_req();
        chk("rr_c1_busy", 64'(req_busy_o), 64'b11);
        tick();
        chk("rr_c2_cyc", 64'(CYC_O), 64'd1);
        chk("rr_c2_we",  64'(WE_O), 64'd1);
        chk("rr_c2_adr", 64'(ADR_O), 64'hA000_0000);
        chk("rr_c2_dat", 64'(DAT_O), 64'h1111_0000);
        chk("rr_c2_sel", 64'(SEL_O), 64'hF);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("rr_c3_cyc",  64'(CYC_O), 64'd0);
        chk("rr_c3_we",   64'(WE_O), 64'd0);
        chk("rr_c3_done", 64'(req_done_o), 64'b01);
        chk("rr_c3_busy", 64'(req_busy_o), 64'b10);
        tick();
        chk("rr_c4_cyc", 64'(CYC_O), 64'd1);
        chk("rr_c4_adr", 64'(ADR_O), 64'hA000_0100);
        chk("rr_c4_dat", 64'(DAT_O), 64'h2222_0001);
        chk("rr_c4_sel", 64'(SEL_O), 64'hC);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("rr_c5_done", 64'(req_done_o), 64'b10);
        chk("rr_c5_busy", 64'(req_busy_o), 64'd0);
        chk("rr_c5_rdat", 64'(req_dat_o), 64'd0);
        tick();

        // Read and write together on ch1: treated as a write, read data untouched
        set_req(1, 1'b1, 1'b1, 32'hB000_0004, 32'h0BAD_CAFE, 4'b0011);
        tick();
        clr_req();
        tick();
        chk("rw_c2_cyc", 64'(CYC_O), 64'd1);
        chk("rw_c2_we",  64'(WE_O), 64'd1);
        chk("rw_c2_sel", 64'(SEL_O), 64'b0011);
        chk("rw_c2_dat", 64'(DAT_O), 64'h0BAD_CAFE);
        ACK_I = 1'b1; DAT_I = 32'h1234_5678;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        chk("rw_c3_done", 64'(req_done_o), 64'b10);
        chk("rw_c3_rdat", 64'(req_dat_o), 64'd0);
        tick();

        // en=0 holds off the grant; en dropping during WAIT does not abort
        set_req(1, 1'b0, 1'b1, 32'hC000_0008, 32'h7777_7777, 4'hF);
        tick();
        clr_req();
        chk("en_c1_busy", 64'(req_busy_o), 64'b10);
        en = 1'b0;
        set_req(0, 1'b1, 1'b0, 32'hC000_0000, 32'h0, 4'hF);
        tick();
        clr_req();
        chk("en_c2_cyc",  64'(CYC_O), 64'd0);
        chk("en_c2_busy", 64'(req_busy_o), 64'b10);
        tick();
        chk("en_c3_cyc", 64'(CYC_O), 64'd0);
        en = 1'b1;
        tick();
        chk("en_c4_cyc", 64'(CYC_O), 64'd1);
        chk("en_c4_adr", 64'(ADR_O), 64'hC000_0008);
        en = 1'b0;
        tick();
        chk("en_c5_cyc_held", 64'(CYC_O), 64'd1);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0; en = 1'b1;
        chk("en_c6_done", 64'(req_done_o), 64'b10);
        chk("en_c6_cyc",  64'(CYC_O), 64'd0);
        tick();

        // Second pulse on busy ch0 is dropped: one transaction, one done
        set_req(0, 1'b1, 1'b0, 32'hD000_0000, 32'h0, 4'hF);
        tick();
        set_req(0, 1'b1, 1'b0, 32'hD000_0040, 32'h0, 4'hF);
        tick();
        chk("dr_c2_cyc", 64'(CYC_O), 64'd1);
        chk("dr_c2_adr", 64'(ADR_O), 64'hD000_0000);
        tick();
        clr_req();
        chk("dr_c3_adr_stable", 64'(ADR_O), 64'hD000_0000);
        ACK_I = 1'b1; DAT_I = 32'hCAFE_F00D;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        chk("dr_c4_done", 64'(req_done_o), 64'b01);
        chk("dr_c4_rdat", 64'(req_dat_o), 64'hCAFE_F00D);
        tick();
        chk("dr_c5_done", 64'(req_done_o), 64'd0);
        chk("dr_c5_busy", 64'(req_busy_o), 64'd0);
        tick();
        chk("dr_c6_cyc", 64'(CYC_O), 64'd0);

        // Both channels again after a ch0 grant: ch1 first, then ch0; ch1 re-requests on its done cycle
        set_req(0, 1'b0, 1'b1, 32'hE000_0000, 32'h3333_3333, 4'b0001);
        set_req(1, 1'b0, 1'b1, 32'hE000_0100, 32'h4444_4444, 4'b1000);
        tick();
        clr_req();
        tick();
        chk("r2_c2_adr", 64'(ADR_O), 64'hE000_0100);
        chk("r2_c2_sel", 64'(SEL_O), 64'b1000);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("r2_c3_done", 64'(req_done_o), 64'b10);
        set_req(1, 1'b0, 1'b1, 32'hE000_0200, 32'h5555_5555, 4'hF);
        tick();
        clr_req();
        chk("r2_c4_adr",  64'(ADR_O), 64'hE000_0000);
        chk("r2_c4_dat",  64'(DAT_O), 64'h3333_3333);
        chk("r2_c4_sel",  64'(SEL_O), 64'b0001);
        chk("r2_c4_busy", 64'(req_busy_o), 64'b11);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("r2_c5_done", 64'(req_done_o), 64'b01);
        tick();
        chk("r2_c6_adr", 64'(ADR_O), 64'hE000_0200);
        chk("r2_c6_cyc", 64'(CYC_O), 64'd1);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("r2_c7_done", 64'(req_done_o), 64'b10);
        chk("r2_c7_busy", 64'(req_busy_o), 64'd0);
        tick();

        // Reset during WAIT: bus drops immediately, no done, next request served normally
        set_req(0, 1'b1, 1'b0, 32'hF000_0000, 32'h0, 4'hF);
        tick();
        clr_req();
        tick();
        chk("rs_c2_cyc", 64'(CYC_O), 64'd1);
        rst = 1'b1;
        #1;
        chk("rs_async_cyc",  64'(CYC_O), 64'd0);
        chk("rs_async_stb",  64'(STB_O), 64'd0);
        chk("rs_async_busy", 64'(req_busy_o), 64'd0);
        @(negedge clk);
        chk("rs_done", 64'(req_done_o), 64'd0);
        rst = 1'b0;
        set_req(1, 1'b0, 1'b1, 32'hF000_0100, 32'h6666_6666, 4'hF);
        tick();
        clr_req();
        tick();
        chk("rs_n_cyc", 64'(CYC_O), 64'd1);
        chk("rs_n_adr", 64'(ADR_O), 64'hF000_0100);
        ACK_I = 1'b1;
        tick();
        ACK_I = 1'b0;
        chk("rs_n_done", 64'(req_done_o), 64'b10);
        tick();

`ifdef T01_WB_TIMEOUT_EN
        // No ACK: abort after the counter reaches TIMEOUT=4
        set_req(0, 1'b1, 1'b0, 32'h9000_0000, 32'h0, 4'hF);
        tick();
        clr_req();
        tick();
        chk("to_c2_cyc", 64'(CYC_O), 64'd1);
        repeat (4) tick();
        chk("to_c6_cyc", 64'(CYC_O), 64'd1);
        chk("to_c6_err", 64'(req_err_o), 64'd0);
        tick();
        chk("to_c7_cyc",  64'(CYC_O), 64'd0);
        chk("to_c7_err",  64'(req_err_o), 64'b01);
        chk("to_c7_done", 64'(req_done_o), 64'd0);
        chk("to_c7_busy", 64'(req_busy_o), 64'd0);
        chk("to_c7_rdat", 64'(req_dat_o), 64'd0);
        tick();
        chk("to_c8_err", 64'(req_err_o), 64'd0);

        // ACK on the timeout edge wins
        set_req(0, 1'b1, 1'b0, 32'h9000_0004, 32'h0, 4'hF);
        tick();
        clr_req();
        tick();
        repeat (4) tick();
        ACK_I = 1'b1; DAT_I = 32'h5A5A_5A5A;
        tick();
        ACK_I = 1'b0; DAT_I = '0;
        chk("ta_c7_done", 64'(req_done_o), 64'b01);
        chk("ta_c7_err",  64'(req_err_o), 64'd0);
        chk("ta_c7_rdat", 64'(req_dat_o), 64'h5A5A_5A5A);
        tick();
`else
        chk("noto_err", 64'(req_err_o), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
